// File: rtl/sprite_anim_pkg.sv
// Shared types for the sprite animation sequencer.
// PINGPONG decode depends on SPRITE_ANIM_PINGPONG_EN.
package sprite_anim_pkg;

  typedef enum logic [1:0] {
    ANIM_LOOP     = 2'd0,
    ANIM_ONCE     = 2'd1,
    ANIM_PINGPONG = 2'd2
  } anim_mode_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    DONE   = 2'd2
  } anim_state_e;

  localparam logic [7:0] ANIM_RESTART_KEY = 8'h2b;

  // Mode 3, and mode 2 without ping-pong support, fall back to LOOP
  function automatic anim_mode_e eff_mode(input logic [1:0] m);
    eff_mode = ANIM_LOOP;
    if (m == ANIM_ONCE)
      eff_mode = ANIM_ONCE;
`ifdef SPRITE_ANIM_PINGPONG_EN
    if (m == ANIM_PINGPONG)
      eff_mode = ANIM_PINGPONG;
`endif
  endfunction

endpackage

// File: rtl/sprite_anim_sequencer_if.sv
// Control/status bundle between game logic and the sprite sequencer.
// master drives controls, slave is the sequencer.
interface sprite_anim_sequencer_if #(
  parameter int FRAME_W = 19
);
  logic [7:0]         keycode;
  logic               press;
  logic [1:0]         mode;
  logic               pause;
  logic [FRAME_W-1:0] base_frame;
  logic [FRAME_W-1:0] frame_num;
  logic               frame_tick;
  logic               done;

  modport master (
    output keycode, press, mode, pause, base_frame,
    input  frame_num, frame_tick, done
  );

  modport slave (
    input  keycode, press, mode, pause, base_frame,
    output frame_num, frame_tick, done
  );
endinterface

// File: rtl/sprite_anim_sequencer_timer.sv
// Per-frame period counter: expires on PERIOD-1, wraps to 0.
// clr wins over en; counter is frozen when en is low.
module anim_period_timer #(
  parameter int CNT_W  = 25,
  parameter int PERIOD = 6240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = expire_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Sprite animation frame sequencer: LOOP / ONCE / PINGPONG stepping.
// PINGPONG and the dir register exist only with SPRITE_ANIM_PINGPONG_EN.
module sprite_anim_sequencer
  import sprite_anim_pkg::*;
#(
  parameter int         NUM_FRAMES  = 11,
  parameter int         PERIOD      = 6240000,
  parameter int         CNT_W       = 25,
  parameter int         FRAME_W     = 19,
  parameter logic [7:0] RESTART_KEY = ANIM_RESTART_KEY
) (
  input logic                    clk,
  input logic                    reset,
  sprite_anim_sequencer_if.slave bus
);

  localparam int IDX_W =
    (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_FRAMES - 1);

  anim_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               tick_q, tick_d;
  logic               restart;
  logic               adv;
  logic               tmr_en, tmr_clr, expire;
  anim_mode_e         mode_e;
`ifdef SPRITE_ANIM_PINGPONG_EN
  logic               dir_q, dir_d;
`endif

  assign restart = (bus.keycode == RESTART_KEY) && bus.press;
  assign mode_e  = eff_mode(bus.mode);

  anim_period_timer #(
    .CNT_W  (CNT_W),
    .PERIOD (PERIOD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .en_i     (tmr_en),
    .clr_i    (tmr_clr),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    tmr_en  = 1'b0;
    tmr_clr = 1'b0;
    adv     = 1'b0;
`ifdef SPRITE_ANIM_PINGPONG_EN
    dir_d   = dir_q;
`endif
    if (restart) begin
      state_d = RUN;
      idx_d   = '0;
      tmr_clr = 1'b1;
`ifdef SPRITE_ANIM_PINGPONG_EN
      dir_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        RUN, PAUSED: begin
          // a low pause in PAUSED resumes counting this same cycle
          if (bus.pause) begin
            state_d = PAUSED;
          end else begin
            state_d = RUN;
            tmr_en  = 1'b1;
            adv     = expire;
          end
        end
        DONE:    tmr_clr = 1'b1;
        default: state_d = RUN;
      endcase
    end

    if (adv) begin
      unique case (1'b1)
        (mode_e == ANIM_ONCE): begin
`ifdef SPRITE_ANIM_PINGPONG_EN
          dir_d = 1'b0;
`endif
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            tick_d = 1'b1;
          end
        end
`ifdef SPRITE_ANIM_PINGPONG_EN
        (mode_e == ANIM_PINGPONG): begin
          tick_d = 1'b1;
          if (LAST == '0) begin
            idx_d = '0;
          end else if (!dir_q) begin
            if (idx_q == LAST) begin
              idx_d = idx_q - IDX_W'(1);
              dir_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            if (idx_q == '0) begin
              idx_d = IDX_W'(1);
              dir_d = 1'b0;
            end else begin
              idx_d = idx_q - IDX_W'(1);
            end
          end
        end
`endif
        default: begin
`ifdef SPRITE_ANIM_PINGPONG_EN
          dir_d  = 1'b0;
`endif
          tick_d = 1'b1;
          idx_d  = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
        end
      endcase
    end

    frame_d = bus.base_frame + FRAME_W'(idx_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      idx_q   <= '0;
      frame_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
    end
  end

`ifdef SPRITE_ANIM_PINGPONG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      dir_q <= 1'b0;
    else
      dir_q <= dir_d;
  end
`endif

  assign bus.frame_num  = frame_q;
  assign bus.frame_tick = tick_q;
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Directed bench: PERIOD=4, NUM_FRAMES=3, base_frame=100,
// plus a PERIOD=1 instance sharing clock and reset.
module tb_sprite_anim_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   pp_exp[5];
  int   prev;

  always #5 clk = ~clk;

  sprite_anim_sequencer_if #(.FRAME_W(19)) bus_a ();
  sprite_anim_sequencer_if #(.FRAME_W(19)) bus_b ();

  sprite_anim_sequencer #(
    .NUM_FRAMES (3),
    .PERIOD     (4),
    .CNT_W      (25),
    .FRAME_W    (19)
  ) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_a)
  );

  sprite_anim_sequencer #(
    .NUM_FRAMES (3),
    .PERIOD     (1),
    .CNT_W      (25),
    .FRAME_W    (19)
  ) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int f,
                       input bit t, input bit d);
    check({tag, "/frame"}, 32'(bus_a.frame_num), f);
    check({tag, "/tick"}, 32'(bus_a.frame_tick), 32'(t));
    check({tag, "/done"}, 32'(bus_a.done), 32'(d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [1:0] m);
    bus_a.mode    = m;
    bus_a.keycode = 8'h2b;
    bus_a.press   = 1'b1;
    step();
    bus_a.press   = 1'b0;
    bus_a.keycode = 8'h00;
  endtask

  initial begin
`ifdef SPRITE_ANIM_PINGPONG_EN
    pp_exp = '{1, 2, 1, 0, 1};
`else
    pp_exp = '{1, 2, 0, 1, 2};
`endif
    bus_a.keycode = 8'h00; bus_a.press = 1'b0;
    bus_a.mode = 2'd0; bus_a.pause = 1'b0;
    bus_a.base_frame = 19'd100;
    bus_b.keycode = 8'h00; bus_b.press = 1'b0;
    bus_b.mode = 2'd0; bus_b.pause = 1'b0;
    bus_b.base_frame = 19'd100;
    #2 rst_n = 1'b0;
    step();
    check("rst/tick", 32'(bus_a.frame_tick), 0);
    check("rst/done", 32'(bus_a.done), 0);
    check("rst_b/tick", 32'(bus_b.frame_tick), 0);
    rst_n = 1'b1;

    for (int k = 1; k <= 40; k++) begin
      step();
      chk_a("loop", 100 + (k / 4) % 3, (k % 4) == 0, 1'b0);
    end

    restart(2'd1);
    chk_a("once_rst", 100, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_a("once", 100 + ((k >= 8) ? 2 : k / 4),
            (k == 4) || (k == 8), k >= 12);
    end

    bus_a.pause = 1'b1;
    step();
    step();
    chk_a("done_pause", 102, 1'b0, 1'b1);
    bus_a.pause = 1'b0;

    restart(2'd1);
    chk_a("done_rst", 100, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk_a("post_rst", 100 + k / 4, k == 4, 1'b0);
    end
    restart(2'd1);
    chk_a("exp_rst", 100, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) step();
    chk_a("exp_rst_hold", 100, 1'b0, 1'b0);
    step();
    chk_a("exp_rst_next", 101, 1'b1, 1'b0);

    restart(2'd0);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 4) chk_a("pre_pause", 101, 1'b1, 1'b0);
    end
    bus_a.pause = 1'b1;
    for (int k = 8; k <= 17; k++) begin
      step();
      chk_a("pause", 101, 1'b0, 1'b0);
    end
    bus_a.pause = 1'b0;
    step();
    chk_a("unpause", 102, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) step();
    chk_a("unpause_hold", 102, 1'b0, 1'b0);
    step();
    chk_a("unpause_next", 100, 1'b1, 1'b0);

    restart(2'd2);
    for (int k = 1; k <= 20; k++) begin
      step();
      prev = (k < 4) ? 0 : pp_exp[k / 4 - 1];
      chk_a("pingpong", 100 + prev, (k % 4) == 0, 1'b0);
    end

    rst_n = 1'b0;
    #1;
    check("arst/tick", 32'(bus_a.frame_tick), 0);
    check("arst/done", 32'(bus_a.done), 0);
    bus_a.mode = 2'd1;
    #1 rst_n = 1'b1;
    step();
    chk_a("rel_once", 100, 1'b0, 1'b0);
    for (int k = 2; k <= 12; k++) step();
    chk_a("once2_done", 102, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst2/done", 32'(bus_a.done), 0);
    check("arst2/tick", 32'(bus_a.frame_tick), 0);
    bus_a.mode = 2'd0;
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_a("rel_loop", 100 + k / 4, k == 4, 1'b0);
      check("p1/frame", 32'(bus_b.frame_num), 100 + k % 3);
      check("p1/tick", 32'(bus_b.frame_tick), 1);
    end

    bus_a.base_frame = 19'd200;
    step();
    chk_a("base_chg", 201, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_anim_sequencer.md
# sprite_anim_sequencer

Parametrised sprite animation frame sequencer for the game's sprite pipeline. It steps a frame index through NUM_FRAMES frames, one per PERIOD clocks, in loop, one-shot or ping-pong mode. It supports pause, keyboard-triggered restart and a per-instance base frame offset. frame_num feeds the sprite ROM address generator; frame_tick and done go to game control logic.

## Interface
- NUM_FRAMES, 11: frames in the animation; ≥1
- PERIOD, 6240000: clocks per frame; ≥1, < 2**CNT_W
- CNT_W, 25: period counter width
- FRAME_W, 19: frame_num width
- RESTART_KEY, 8'h2b: keycode that restarts the animation
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- keycode  in  8  current keyboard keycode
- press  in  1  key-pressed qualifier
- mode  in  2  0 LOOP, 1 ONCE, 2 PINGPONG, 3 treated as LOOP
- pause  in  1  freeze animation while high
- base_frame  in  FRAME_W  offset added to the frame index
- frame_num  out  FRAME_W  registered base_frame + idx
- frame_tick  out  1  one-cycle pulse on the cycle frame_num shows a newly advanced frame
- done  out  1  high while in DONE (ONCE mode finished)

## Operation
- Internal state: counter [CNT_W], idx [$clog2(NUM_FRAMES) min 1], dir (up/down), fsm {RUN, PAUSED, DONE}.
- Reset (reset low, async): counter=0, idx=0, dir=up, fsm=RUN, frame_num=base_frame sampled after reset release, frame_tick=0, done=0.
- Restart = (keycode==RESTART_KEY && press), synchronous. Priority is restart > pause > advance.
- Restart: counter=0, idx=0, dir=up, fsm=RUN, done=0. A restart held high pins frame 0.
- RUN: counter increments. At counter==PERIOD-1, counter goes to 0 and the frame advances.
- RUN→PAUSED when pause=1. PAUSED→RUN when pause=0. In PAUSED, counter and idx are frozen and there is no tick.
- Advance, LOOP: idx = (idx==NUM_FRAMES-1) ? 0 : idx+1.
- Advance, ONCE: if idx<NUM_FRAMES-1, idx+1. At NUM_FRAMES-1, enter DONE with no tick. In DONE, idx stays NUM_FRAMES-1, counter holds 0 and done=1. DONE is left only by restart or reset; pause is ignored in DONE.
- Advance, PINGPONG: idx steps in dir, reversing at the ends. Sequence is 0,1,…,N-1,N-2,…,1,0,1,…
- NUM_FRAMES=1: idx stays 0. LOOP/PINGPONG still tick every period. ONCE enters DONE after the first period.
- mode is sampled at each advance. When the mode is not PINGPONG, dir is forced up on the next advance. A change from ONCE while in DONE has no effect until restart.
- frame_num = base_frame + idx, modulo 2**FRAME_W, registered every cycle. A base_frame change appears one cycle later.

## Timing
- Advance edge: idx, frame_num and frame_tick all update on the same clock edge. Latency is PERIOD clocks per frame from restart.
- PERIOD=1: advances every clock while RUN; frame_tick stays high continuously.
- Pause asserted on the expiry cycle blocks that advance; the counter holds PERIOD-1 and the advance happens on the first RUN cycle after release.
- Restart and expiry in the same cycle: restart wins and no tick is produced.
- Reset mid-operation: all state clears immediately (async); the sequence resumes from frame 0 on the first clock after release.

## Configuration
- SPRITE_ANIM_PINGPONG_EN defined: PINGPONG mode and the dir register are implemented.
- Macro undefined: dir logic is removed; mode 2 behaves as LOOP.

## Structure
- Package sprite_anim_pkg holds:
  - typedef anim_mode_e {ANIM_LOOP, ANIM_ONCE, ANIM_PINGPONG}
  - typedef anim_state_e {RUN, PAUSED, DONE}
  - localparam ANIM_RESTART_KEY = 8'h2b
- Sub-module anim_period_timer: CNT_W counter with enable and clear inputs and an expire output at PERIOD-1.
- The FSM and index logic live in the top module.

## Test plan
All scenarios use PERIOD=4, NUM_FRAMES=3, base_frame=100.
- LOOP, free run 40 clocks → frame_num 100,101,102,100,… changing every 4 clocks, with frame_tick coincident with each change.
- ONCE → 100,101,102; then 4 clocks later done=1 with no tick, and frame_num holds 102 indefinitely.
- PINGPONG → 100,101,102,101,100,101; with the macro undefined → 100,101,102,100.
- pause high for 10 clocks in frame 101, including across an expiry → frame_num held and no tick; the advance to 102 comes on the first clock after release.
- keycode=8'h2b, press=1 for 1 clock in DONE, and again on an expiry cycle → frame 100, done=0, no tick, next advance 4 clocks later.
- reset pulsed low mid-frame → outputs clear asynchronously (frame_tick=0, done=0); frame_num=100 on the first clock after release. PERIOD=1 variant: tick every clock.
